// File: rtl/sw_debounce_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_irq_ctrl_pkg
//
// Purpose: shared definitions for the slide-switch debounce / interrupt
// controller: register word addresses, edge-type encodings for CTRL[1:0],
// CTRL bit positions, the default sample period and a small helper that
// picks the edges of interest for one switch.
//
// Contents:
//   ADDR_*                 register word addresses on the Avalon-MM slave
//   edge_sel_e             edge type selected by CTRL[1:0]
//   CTRL_*                 bit indices / width of the CTRL register
//   PRESCALE_RST_DEFAULT   reset sample period (10 ms at 50 MHz)
//   edge_hit()             1 when the selected edge type occurred
// ---------------------------------------------------------------------------
package sw_debounce_irq_ctrl_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_RAW     = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_PERIOD  = 3'd4;
   localparam logic [2:0] ADDR_CTRL    = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_sel_e;

   localparam int CTRL_EDGE_LSB = 0;
   localparam int CTRL_EDGE_MSB = 1;
   localparam int CTRL_ENABLE   = 2;
   localparam int CTRL_W        = 3;

   localparam int PRESCALE_RST_DEFAULT = 500000;

   // Decide whether the debounced transitions of one switch should be
   // captured, given the edge type currently programmed in CTRL.
   function automatic logic edge_hit(input edge_sel_e sel,
                                     input logic rise,
                                     input logic fall);
      edge_hit = 1'b0;
      case (sel)
         EDGE_RISE: edge_hit = rise;
         EDGE_FALL: edge_hit = fall;
         EDGE_BOTH: edge_hit = rise | fall;
         EDGE_NONE: edge_hit = 1'b0;
         default:   edge_hit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sw_debounce_irq_ctrl_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
//
// Purpose: conditioning for a single slide switch. The asynchronous pin is
// brought into the clk domain through a two-flop synchroniser, then a
// stability counter only accepts a new level after STABLE_N consecutive
// sample ticks that all disagree with the current debounced level.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   sw        in   raw switch pin (asynchronous)
//   tick      in   one-cycle sample strobe, already gated by enable
//   raw_sync  out  synchronised (not debounced) level
//   level     out  debounced level
// ---------------------------------------------------------------------------
module sw_debounce_bit #(
   parameter int STABLE_N = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw,
   input  logic tick,
   output logic raw_sync,
   output logic level
);

   // Counter value at which the STABLE_N-th differing sample is being seen.
   localparam logic [3:0] STABLE_LAST = 4'(STABLE_N - 1);

   logic       sync_meta;
   logic [3:0] stab_cnt;

   // Two-flop synchroniser; the first stage may go metastable and is never
   // looked at by anything but the second stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         raw_sync  <= 1'b0;
      end else begin
         sync_meta <= sw;
         raw_sync  <= sync_meta;
      end
   end

   // Stability counter. Any sample that agrees with the debounced level
   // restarts the count, so only an unbroken run of STABLE_N disagreeing
   // samples flips the level. Between ticks everything holds, which is also
   // how a disabled controller freezes the debounce state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stab_cnt <= '0;
         level    <= 1'b0;
      end else if (tick) begin
         if (raw_sync != level) begin
            if (stab_cnt == STABLE_LAST) begin
               level    <= ~level;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + 4'd1;
            end
         end else begin
            stab_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sw_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// sw_debounce_irq_ctrl
//
// Purpose: Avalon-MM slave for the DE10-Lite slide switches. Each switch is
// synchronised and debounced, debounced edges of the programmed type are
// latched into sticky capture bits, and a masked level interrupt is raised
// towards the Nios II. A prescaler sets how often the switches are sampled.
//
// Register map (word address):
//   0 DATA     R    debounced levels
//   1 RAW      R    synchronised raw levels
//   2 MASK     RW   interrupt mask
//   3 EDGECAP  R/W1C captured edges
//   4 PERIOD   RW   sample period in clk cycles minus one
//   5 CTRL     RW   [1:0] edge type, [2] enable
//   6-7        read 0, writes ignored
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   chipselect  in   slave select
//   address     in   register word address
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   raw switch pins, asynchronous
//   readdata    out  registered read data, one cycle after address
//   irq         out  registered level interrupt, active high
// ---------------------------------------------------------------------------
module sw_debounce_irq_ctrl
   import sw_debounce_irq_ctrl_pkg::*;
#(
   parameter int WIDTH        = 10,
   parameter int PRESCALE_W   = 20,
   parameter int PRESCALE_RST = PRESCALE_RST_DEFAULT,
   parameter int STABLE_N     = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic [2:0]       address,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic                  wr_en;
   logic                  unused_wdata;
   logic [PRESCALE_W-1:0] period;
   logic [PRESCALE_W-1:0] presc_cnt;
   logic                  period_reload;
   logic                  tick_raw;
   logic                  tick;
   logic [CTRL_W-1:0]     ctrl;
   logic [WIDTH-1:0]      mask;
   logic [WIDTH-1:0]      edgecap;
   logic [WIDTH-1:0]      edge_clr;
   logic [WIDTH-1:0]      edge_set;
   logic [WIDTH-1:0]      raw_sync;
   logic [WIDTH-1:0]      deb;
   logic [WIDTH-1:0]      deb_d;
   logic [31:0]           read_mux;
   edge_sel_e             edge_sel;

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;
   assign edge_sel     = edge_sel_e'(ctrl[CTRL_EDGE_MSB:CTRL_EDGE_LSB]);

   // Prescaler: a down-counter that strobes tick_raw while it sits at zero
   // and reloads from PERIOD, so PERIOD=0 samples every cycle. A PERIOD
   // write is remembered for one cycle and forces a reload, making the new
   // period start right away instead of after the old count runs out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_cnt     <= '0;
         period_reload <= 1'b0;
      end else begin
         period_reload <= wr_en && (address == ADDR_PERIOD);
         if (period_reload || tick_raw) begin
            presc_cnt <= period;
         end else begin
            presc_cnt <= presc_cnt - PRESCALE_W'(1);
         end
      end
   end

   assign tick_raw = (presc_cnt == '0);
   assign tick     = tick_raw & ctrl[CTRL_ENABLE];

   // One synchroniser + debouncer per switch sharing the gated tick, plus
   // the per-switch choice of which debounced transitions get captured.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_N (STABLE_N)
      ) u_bit (
         .clk      (clk),
         .reset_n  (reset_n),
         .sw       (in_port[i]),
         .tick     (tick),
         .raw_sync (raw_sync[i]),
         .level    (deb[i])
      );

      assign edge_set[i] = edge_hit(edge_sel, deb[i] & ~deb_d[i], ~deb[i] & deb_d[i]);
   end

   // Writable configuration registers. PERIOD comes out of reset at the
   // default sample period rather than zero so the switches are debounced
   // sensibly as soon as software sets the enable bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask   <= '0;
         period <= PRESCALE_W'(PRESCALE_RST);
         ctrl   <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_MASK:   mask   <= writedata[WIDTH-1:0];
            ADDR_PERIOD: period <= writedata[PRESCALE_W-1:0];
            ADDR_CTRL:   ctrl   <= writedata[CTRL_W-1:0];
            default:     ;
         endcase
      end
   end

   assign edge_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

   // Edge capture and interrupt. The clear is applied before the new edges
   // are OR-ed in so a write-1-to-clear racing a fresh edge leaves the bit
   // set and the event is not lost. irq looks at the registered capture and
   // mask, hence it follows a mask or clear write by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d   <= '0;
         edgecap <= '0;
         irq     <= 1'b0;
      end else begin
         deb_d   <= deb;
         edgecap <= (edgecap & ~edge_clr) | edge_set;
         irq     <= |(edgecap & mask);
      end
   end

   // Read multiplexer; unused upper bits and unmapped addresses read 0.
   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA:    read_mux[WIDTH-1:0]      = deb;
         ADDR_RAW:     read_mux[WIDTH-1:0]      = raw_sync;
         ADDR_MASK:    read_mux[WIDTH-1:0]      = mask;
         ADDR_EDGECAP: read_mux[WIDTH-1:0]      = edgecap;
         ADDR_PERIOD:  read_mux[PRESCALE_W-1:0] = period;
         ADDR_CTRL:    read_mux[CTRL_W-1:0]     = ctrl;
         default:      read_mux                 = '0;
      endcase
   end

   // readdata follows address every cycle with one cycle of latency; there
   // is no read strobe, so reads have no side effects.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= read_mux;
      end
   end

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_irq_ctrl
//
// Self-checking bench for sw_debounce_irq_ctrl: a table of register accesses
// with hand-derived expectations, hand-written multi-cycle sequences for
// glitch rejection, capture/clear, falling-edge mode, clear-vs-set collision
// and reset during debounce, then randomized traffic compared every cycle
// against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_sw_debounce_irq_ctrl;

   localparam int WIDTH        = 10;
   localparam int STABLE_N     = 4;
   localparam int PRESCALE_RST = 500000;

   typedef struct {
      logic [2:0]  addr;
      bit          wr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_irq;
      string       name;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             chipselect = 1'b0;
   logic [2:0]       address = '0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = '0;
   logic [WIDTH-1:0] in_port = '0;
   logic [31:0]      readdata;
   logic             irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [WIDTH-1:0] m_pipe [2];
   logic [WIDTH-1:0] m_deb, m_debd, m_edge, m_mask;
   int               m_stab [WIDTH];
   int               m_cnt;
   bit               m_reload;
   int               m_period;
   logic [2:0]       m_ctrl;
   logic [31:0]      m_rd;
   bit               m_irq;

   sw_debounce_irq_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      m_deb     = '0;
      m_debd    = '0;
      m_edge    = '0;
      m_mask    = '0;
      foreach (m_stab[i]) m_stab[i] = 0;
      m_cnt     = 0;
      m_reload  = 1'b0;
      m_period  = PRESCALE_RST;
      m_ctrl    = '0;
      m_rd      = '0;
      m_irq     = 1'b0;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic modelStep();
      logic [WIDTH-1:0] raw, rise, fall, sel, n_deb, clr;
      bit wr, smp;
      if (!reset_n) begin
         modelReset();
         return;
      end
      wr  = chipselect && !write_n;
      raw = m_pipe[1];
      smp = m_ctrl[2] && (m_cnt == 0);

      case (address)
         3'd0:    m_rd = 32'(m_deb);
         3'd1:    m_rd = 32'(raw);
         3'd2:    m_rd = 32'(m_mask);
         3'd3:    m_rd = 32'(m_edge);
         3'd4:    m_rd = 32'(m_period);
         3'd5:    m_rd = 32'(m_ctrl);
         default: m_rd = 32'd0;
      endcase
      m_irq = |(m_edge & m_mask);

      rise = m_deb & ~m_debd;
      fall = ~m_deb & m_debd;
      case (m_ctrl[1:0])
         2'd0:    sel = rise;
         2'd1:    sel = fall;
         2'd2:    sel = rise | fall;
         default: sel = '0;
      endcase
      clr    = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
      m_edge = (m_edge & ~clr) | sel;
      m_debd = m_deb;

      // A level is accepted after STABLE_N consecutive disagreeing samples.
      n_deb = m_deb;
      if (smp) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (raw[i] != m_deb[i]) begin
               m_stab[i] = m_stab[i] + 1;
               if (m_stab[i] == STABLE_N) begin
                  n_deb[i]  = ~m_deb[i];
                  m_stab[i] = 0;
               end
            end else begin
               m_stab[i] = 0;
            end
         end
      end
      m_deb = n_deb;

      m_cnt    = (m_reload || m_cnt == 0) ? m_period : m_cnt - 1;
      m_reload = wr && (address == 3'd4);

      if (wr) begin
         case (address)
            3'd2:    m_mask   = writedata[WIDTH-1:0];
            3'd4:    m_period = int'(writedata[19:0]);
            3'd5:    m_ctrl   = writedata[2:0];
            default: ;
         endcase
      end

      m_pipe[1] = m_pipe[0];
      m_pipe[0] = in_port;
   endtask

   task automatic checkOutput();
      check("model_readdata", readdata, m_rd);
      check("model_irq", 32'(irq), 32'(m_irq));
   endtask

   // One bus cycle: drive, clock, advance model, sample just after the edge.
   task automatic applyStimulus(input bit cs, input logic [2:0] a, input bit w, input logic [31:0] d);
      chipselect = cs;
      address    = a;
      write_n    = !w;
      writedata  = d;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic wrReg(input logic [2:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, 1'b1, d);
   endtask

   task automatic expectRead(input string name, input logic [2:0] a, input logic [31:0] exp);
      applyStimulus(1'b1, a, 1'b0, 32'd0);
      check(name, readdata, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0);
   endtask

   task automatic doReset(input logic [WIDTH-1:0] sw);
      reset_n = 1'b0;
      modelReset();
      in_port = sw;
      idle(3);
      check("reset_readdata", readdata, 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      vec_t        vecs[$];
      logic [2:0]  ra;
      logic [31:0] rd_val;

      modelReset();

      // Reset with all switches up, then bring the controller to life.
      vecs.push_back('{3'd4, 1'b0, 32'd0,      32'd500000, 1'b0, "period_reset_val"});
      vecs.push_back('{3'd4, 1'b1, 32'd0,      32'd500000, 1'b0, "period_write_old"});
      vecs.push_back('{3'd4, 1'b0, 32'd0,      32'd0,      1'b0, "period_readback"});
      vecs.push_back('{3'd5, 1'b1, 32'd4,      32'd0,      1'b0, "ctrl_write_old"});
      vecs.push_back('{3'd5, 1'b0, 32'd0,      32'd4,      1'b0, "ctrl_readback"});
      vecs.push_back('{3'd1, 1'b0, 32'd0,      32'h3FF,    1'b0, "raw_level"});
      vecs.push_back('{3'd6, 1'b1, 32'hFFFF,   32'd0,      1'b0, "addr6_zero"});
      vecs.push_back('{3'd0, 1'b0, 32'd0,      32'd0,      1'b0, "data_before_accept"});
      vecs.push_back('{3'd0, 1'b0, 32'd0,      32'h3FF,    1'b0, "data_accepted"});
      vecs.push_back('{3'd3, 1'b0, 32'd0,      32'h3FF,    1'b0, "edgecap_rise"});
      vecs.push_back('{3'd2, 1'b1, 32'h8,      32'd0,      1'b0, "mask_write_old"});
      vecs.push_back('{3'd2, 1'b0, 32'd0,      32'h8,      1'b1, "mask_irq"});
      vecs.push_back('{3'd3, 1'b1, 32'h3FF,    32'h3FF,    1'b1, "w1c_write_old"});
      vecs.push_back('{3'd3, 1'b0, 32'd0,      32'd0,      1'b0, "edgecap_cleared"});
      vecs.push_back('{3'd7, 1'b0, 32'd0,      32'd0,      1'b0, "addr7_zero"});
      vecs.push_back('{3'd0, 1'b0, 32'd0,      32'h3FF,    1'b0, "data_hold"});

      doReset(10'h3FF);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(1'b1, vecs[i].addr, vecs[i].wr, vecs[i].wd);
         check({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
         check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
      end

      // Short glitch is rejected, a held level is captured and cleared.
      doReset('0);
      wrReg(3'd4, 32'd0);
      wrReg(3'd5, 32'd4);
      wrReg(3'd2, 32'h008);
      idle(3);
      in_port = 10'h008;
      idle(2);
      in_port = '0;
      idle(10);
      expectRead("glitch_data", 3'd0, 32'd0);
      expectRead("glitch_edgecap", 3'd3, 32'd0);
      in_port = 10'h008;
      idle(10);
      expectRead("hold_data", 3'd0, 32'h008);
      expectRead("hold_edgecap", 3'd3, 32'h008);
      check("hold_irq", 32'(irq), 32'd1);
      wrReg(3'd3, 32'h008);
      expectRead("clear_edgecap", 3'd3, 32'd0);
      check("clear_irq", 32'(irq), 32'd0);

      // Falling-edge mode only captures the 1->0 transition.
      doReset('0);
      wrReg(3'd4, 32'd0);
      wrReg(3'd5, 32'd5);
      wrReg(3'd2, 32'h3FF);
      idle(3);
      in_port = 10'h001;
      idle(10);
      expectRead("fall_mode_data_hi", 3'd0, 32'h001);
      expectRead("fall_mode_no_rise", 3'd3, 32'd0);
      check("fall_mode_irq_lo", 32'(irq), 32'd0);
      in_port = '0;
      idle(10);
      expectRead("fall_mode_capture", 3'd3, 32'h001);
      check("fall_mode_irq_hi", 32'(irq), 32'd1);

      // Clear lands on the very cycle bit5's debounced rise is captured.
      doReset('0);
      wrReg(3'd4, 32'd0);
      wrReg(3'd5, 32'd4);
      wrReg(3'd2, 32'h020);
      idle(3);
      in_port = 10'h020;
      idle(6);
      wrReg(3'd3, 32'h020);
      expectRead("collision_set_wins", 3'd3, 32'h020);
      check("collision_irq", 32'(irq), 32'd1);

      // Reset with STABLE_N-1 samples already counted discards them.
      doReset('0);
      wrReg(3'd4, 32'd0);
      wrReg(3'd5, 32'd4);
      idle(2);
      in_port = 10'h002;
      idle(5);
      reset_n = 1'b0;
      modelReset();
      #1;
      check("midrst_async_irq", 32'(irq), 32'd0);
      idle(2);
      reset_n = 1'b1;
      expectRead("midrst_data", 3'd0, 32'd0);
      wrReg(3'd4, 32'd0);
      wrReg(3'd5, 32'd4);
      for (int k = 0; k < STABLE_N; k++) expectRead("midrst_still_low", 3'd0, 32'd0);
      expectRead("midrst_accept", 3'd0, 32'h002);

      // Randomized traffic against the model.
      doReset(WIDTH'($urandom));
      wrReg(3'd4, 32'($urandom_range(0, 2)));
      wrReg(3'd5, 32'($urandom_range(4, 7)));
      wrReg(3'd2, $urandom);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) in_port[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
         ra = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 7) begin
            applyStimulus(1'($urandom), ra, 1'b0, $urandom);
         end else begin
            if (ra == 3'd4)      rd_val = 32'($urandom_range(0, 2));
            else if (ra == 3'd5) rd_val = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'd4 : 32'd0);
            else                 rd_val = $urandom;
            applyStimulus(($urandom_range(0, 7) != 0), ra, 1'b1, rd_val);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
